// File: rtl/la_bist_pkg.sv
// Shared encodings for the March C- BIST: FSM states, element codes and the
// per-element operation table (direction, read expectation, write data).
package la_bist_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef logic [2:0] elem_t;

    localparam elem_t E0 = 3'd0;
    localparam elem_t E1 = 3'd1;
    localparam elem_t E2 = 3'd2;
    localparam elem_t E3 = 3'd3;
    localparam elem_t E4 = 3'd4;
    localparam elem_t E5 = 3'd5;

    typedef struct packed {
        logic down;    // walk addresses N-1..0
        logic has_rd;
        logic has_wr;
        logic rd_val;  // expected read data, replicated across DW
        logic wr_val;  // write data, replicated across DW
    } elem_cfg_t;

    function automatic logic elem_is_down(elem_t e);
        return (e == E3) || (e == E4);
    endfunction

    function automatic elem_cfg_t elem_cfg(elem_t e);
        elem_cfg_t c;
        c      = '0;
        c.down = elem_is_down(e);
        case (e)
            E0:      begin c.has_wr = 1'b1; c.wr_val = 1'b0; end
            E1, E3:  begin c.has_rd = 1'b1; c.rd_val = 1'b0; c.has_wr = 1'b1; c.wr_val = 1'b1; end
            E2, E4:  begin c.has_rd = 1'b1; c.rd_val = 1'b1; c.has_wr = 1'b1; c.wr_val = 1'b0; end
            E5:      begin c.has_rd = 1'b1; c.rd_val = 1'b0; end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/la_bist_addrgen.sv
// Loadable up/down address counter for the BIST walk; tc flags the last
// address of the current direction.
module la_bist_addrgen #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          load,
    input  logic          load_down,
    input  logic          step,
    input  logic          down,
    output logic [AW-1:0] addr,
    output logic          tc
);

    localparam logic [AW-1:0] ONE = AW'(1);

    logic [AW-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = load_down ? {AW{1'b1}} : {AW{1'b0}};
        end else if (step) begin
            addr_d = down ? (addr_q - ONE) : (addr_q + ONE);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) addr_q <= '0;
        else         addr_q <= addr_d;
    end

    assign addr = addr_q;
    assign tc   = down ? (addr_q == {AW{1'b0}}) : (addr_q == {AW{1'b1}});

endmodule

// File: rtl/la_tdpram_bist.sv
// March C- BIST controller driving one la_tdpram port: op sequencer, one-cycle
// read compare pipeline and sticky first-failure result registers.
module la_tdpram_bist
    import la_bist_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 10,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [AW-1:0] fail_addr,
    output logic [2:0]    fail_elem,
    output logic [CW-1:0] fail_count,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [DW-1:0] mem_wmask,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    logic [1:0]    state_q, state_d;
    elem_t         elem_q, elem_d;
    logic          phase_q, phase_d;   // 0 = read slot, 1 = write slot of a paired element

    logic          cmp_vld_q, cmp_vld_d;
    logic [DW-1:0] cmp_exp_q, cmp_exp_d;
    logic [AW-1:0] cmp_addr_q, cmp_addr_d;
    elem_t         cmp_elem_q, cmp_elem_d;

    logic          fail_q, fail_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d;
    elem_t         fail_elem_q, fail_elem_d;
    logic [CW-1:0] fail_count_q, fail_count_d;

    logic          ag_load, ag_load_down, ag_step, ag_tc;
    logic [AW-1:0] ag_addr;

    elem_cfg_t     cfg;
    logic          in_run, paired, op_rd, op_wr, addr_adv, elem_last, run_entry, mismatch;

    la_bist_addrgen #(.AW(AW)) u_addrgen (
        .clk       (clk),
        .nreset    (nreset),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .down      (cfg.down),
        .addr      (ag_addr),
        .tc        (ag_tc)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cfg          = elem_cfg(elem_q);
        in_run       = (state_q == ST_RUN);
        paired       = cfg.has_rd & cfg.has_wr;
        op_rd        = in_run & cfg.has_rd & ~(cfg.has_wr & phase_q);
        op_wr        = in_run & cfg.has_wr & (~cfg.has_rd | phase_q);
        addr_adv     = in_run & (~paired | phase_q);
        elem_last    = addr_adv & ag_tc;
        run_entry    = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;

        state_d      = state_q;
        elem_d       = elem_q;
        phase_d      = phase_q;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    elem_d  = E0;
                    phase_d = 1'b0;
                    ag_load = 1'b1;
                end
            end
            ST_RUN: begin
                phase_d = paired & ~phase_q;
                if (elem_last) begin
                    if (elem_q == E5) begin
                        state_d = ST_DRAIN;
                    end else begin
                        elem_d       = elem_q + 3'd1;
                        ag_load      = 1'b1;
                        ag_load_down = elem_is_down(elem_q + 3'd1);
                    end
                end else if (addr_adv) begin
                    ag_step = 1'b1;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmp_vld_d    = op_rd;
        cmp_exp_d    = {DW{cfg.rd_val}};
        cmp_addr_d   = ag_addr;
        cmp_elem_d   = elem_q;
        mismatch     = cmp_vld_q && (mem_dout != cmp_exp_q);

        fail_d       = fail_q;
        fail_addr_d  = fail_addr_q;
        fail_elem_d  = fail_elem_q;
        fail_count_d = fail_count_q;

        if (run_entry) begin
            fail_d       = 1'b0;
            fail_addr_d  = '0;
            fail_elem_d  = E0;
            fail_count_d = '0;
        end else if (mismatch) begin
            fail_d = 1'b1;
            if (fail_count_q != {CW{1'b1}}) fail_count_d = fail_count_q + CW'(1);
            if (!fail_q) begin
                fail_addr_d = cmp_addr_q;
                fail_elem_d = cmp_elem_q;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= ST_IDLE;
            elem_q       <= E0;
            phase_q      <= 1'b0;
            cmp_vld_q    <= 1'b0;
            cmp_exp_q    <= '0;
            cmp_addr_q   <= '0;
            cmp_elem_q   <= E0;
            fail_q       <= 1'b0;
            fail_addr_q  <= '0;
            fail_elem_q  <= E0;
            fail_count_q <= '0;
        end else begin
            state_q      <= state_d;
            elem_q       <= elem_d;
            phase_q      <= phase_d;
            cmp_vld_q    <= cmp_vld_d;
            cmp_exp_q    <= cmp_exp_d;
            cmp_addr_q   <= cmp_addr_d;
            cmp_elem_q   <= cmp_elem_d;
            fail_q       <= fail_d;
            fail_addr_q  <= fail_addr_d;
            fail_elem_q  <= fail_elem_d;
            fail_count_q <= fail_count_d;
        end
    end

    // Outputs decode straight from flops, so an async reset clears them at once.
    assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done       = (state_q == ST_DONE);
    assign fail       = fail_q;
    assign fail_addr  = fail_addr_q;
    assign fail_elem  = fail_elem_q;
    assign fail_count = fail_count_q;
    assign mem_ce     = in_run;
    assign mem_we     = op_wr;
    assign mem_wmask  = op_wr ? {DW{1'b1}} : {DW{1'b0}};
    assign mem_din    = op_wr ? {DW{cfg.wr_val}} : {DW{1'b0}};
    assign mem_addr   = in_run ? ag_addr : {AW{1'b0}};

endmodule

// File: tb/tb_la_tdpram_bist.sv
// Directed bench for la_tdpram_bist at AW=4 DW=8 with a registered-read RAM
// model that injects stuck-at faults; a CW=2 instance checks saturation.
module tb_la_tdpram_bist;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk    = 1'b0;
    logic          nreset = 1'b1;
    logic          start  = 1'b0;

    logic          busy, done, fail, mem_ce, mem_we;
    logic [AW-1:0] fail_addr, mem_addr;
    logic [2:0]    fail_elem;
    logic [15:0]   fail_count;
    logic [DW-1:0] mem_wmask, mem_din, mem_dout;

    logic          busy_b, done_b, fail_b, mem_ce_b, mem_we_b;
    logic [AW-1:0] fail_addr_b, mem_addr_b;
    logic [2:0]    fail_elem_b;
    logic [1:0]    fail_count_b;
    logic [DW-1:0] mem_wmask_b, mem_din_b, mem_dout_b;

    logic [DW-1:0] ram_a [16];
    logic [DW-1:0] ram_b [16];
    logic [DW-1:0] sa1_mask   = '0;
    logic [DW-1:0] sa0_mask   = '0;
    logic [AW-1:0] fault_addr = '0;
    logic          fault_all  = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    la_tdpram_bist #(.DW(DW), .AW(AW), .CW(16)) u_dut (
        .clk(clk), .nreset(nreset), .start(start), .busy(busy), .done(done),
        .fail(fail), .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_count(fail_count),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    la_tdpram_bist #(.DW(DW), .AW(AW), .CW(2)) u_dut_cw2 (
        .clk(clk), .nreset(nreset), .start(start), .busy(busy_b), .done(done_b),
        .fail(fail_b), .fail_addr(fail_addr_b), .fail_elem(fail_elem_b), .fail_count(fail_count_b),
        .mem_ce(mem_ce_b), .mem_we(mem_we_b), .mem_wmask(mem_wmask_b), .mem_addr(mem_addr_b),
        .mem_din(mem_din_b), .mem_dout(mem_dout_b)
    );

    function automatic logic [DW-1:0] faulty(logic [DW-1:0] v, logic [AW-1:0] a);
        if (fault_all || (a == fault_addr)) return (v | sa1_mask) & ~sa0_mask;
        return v;
    endfunction

    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) ram_a[mem_addr] <= (ram_a[mem_addr] & ~mem_wmask) | (mem_din & mem_wmask);
            else        mem_dout <= faulty(ram_a[mem_addr], mem_addr);
        end
        if (mem_ce_b) begin
            if (mem_we_b) ram_b[mem_addr_b] <= (ram_b[mem_addr_b] & ~mem_wmask_b) | (mem_din_b & mem_wmask_b);
            else          mem_dout_b <= faulty(ram_b[mem_addr_b], mem_addr_b);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected port activity at busy cycle k, derived from the March C- layout.
    function automatic void exp_op(input int k, output logic ce, output logic we,
                                   output logic [AW-1:0] a, output logic [DW-1:0] d);
        int j, e, r, s, av;
        ce = 1'b0; we = 1'b0; a = '0; d = '0; av = 0;
        if (k < 16) begin
            ce = 1'b1; we = 1'b1; av = k;
        end else if (k < 144) begin
            j  = k - 16;
            e  = 1 + j / 32;
            r  = j % 32;
            s  = r / 2;
            ce = 1'b1;
            we = (r % 2) == 1;
            av = (e <= 2) ? s : 15 - s;
            if (we) d = ((e == 1) || (e == 3)) ? 8'hFF : 8'h00;
        end else if (k < 160) begin
            ce = 1'b1; av = k - 144;
        end
        a = av[AW-1:0];
    endfunction

    task automatic pulse_start;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Call at the first RUN negedge; walks until done or a cycle budget expires.
    task automatic measure(output int busy_cyc, output int ce_cyc, output int proto_err);
        logic          e_ce, e_we;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d;
        int            k;
        k = 0; busy_cyc = 0; ce_cyc = 0; proto_err = 0;
        while (!done && k < 400) begin
            if (busy)   busy_cyc++;
            if (mem_ce) ce_cyc++;
            exp_op(k, e_ce, e_we, e_a, e_d);
            if ({mem_ce, mem_we, mem_addr, mem_din, mem_wmask} !== {e_ce, e_we, e_a, e_d, {DW{e_we}}})
                proto_err++;
            k++;
            @(negedge clk);
        end
    endtask

    initial begin
        int bc, cc, pe, n;

        // Reset state
        #2 nreset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy_done_fail", {29'd0, busy, done, fail}, 32'd0);
        check("rst_fail_info", {9'd0, fail_addr, fail_elem, fail_count}, 32'd0);
        check("rst_mem_ctl", {mem_ce, mem_we, mem_addr, mem_wmask, mem_din}, 32'd0);
        @(negedge clk) nreset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_start_busy", {30'd0, busy, done}, 32'd0);

        // Clean RAM
        pulse_start;
        check("clean_first_op", {mem_ce, mem_we, mem_addr, mem_din}, {1'b1, 1'b1, 4'd0, 8'h00});
        measure(bc, cc, pe);
        check("clean_busy_cycles", bc, 161);
        check("clean_ce_cycles", cc, 160);
        check("clean_op_sequence", pe, 0);
        check("clean_done", {30'd0, done, busy}, 32'd2);
        check("clean_fail", {fail, fail_count}, 17'd0);
        check("clean_cw2_fail", {28'd0, done_b, fail_b, fail_count_b}, 32'd8);

        // Bit 3 stuck-at-1 at addr 5
        sa1_mask = 8'h08; sa0_mask = 8'h00; fault_addr = 4'd5;
        pulse_start;
        measure(bc, cc, pe);
        check("sa1_busy_cycles", bc, 161);
        check("sa1_done_fail", {30'd0, done, fail}, 32'd3);
        check("sa1_fail_addr", fail_addr, 5);
        check("sa1_fail_elem", fail_elem, 1);
        check("sa1_fail_count", fail_count, 3);

        // Bit 0 stuck-at-0 at addr 15
        sa1_mask = 8'h00; sa0_mask = 8'h01; fault_addr = 4'd15;
        pulse_start;
        measure(bc, cc, pe);
        check("sa0_done_fail", {30'd0, done, fail}, 32'd3);
        check("sa0_fail_addr", fail_addr, 15);
        check("sa0_fail_elem", fail_elem, 2);
        check("sa0_fail_count", fail_count, 2);

        // start held high: restart from DONE clears the prior fail
        sa0_mask = 8'h00;
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        check("hold_entry_clears", {29'd0, busy, done, fail}, 32'd4);
        check("hold_entry_count", fail_count, 0);
        measure(bc, cc, pe);
        check("hold_busy_cycles", bc, 161);
        check("hold_op_sequence", pe, 0);
        check("hold_done_clean", {30'd0, done, fail}, 32'd2);
        @(negedge clk);
        check("hold_one_done_cycle", {30'd0, busy, done}, 32'd2);
        start = 1'b0;
        n = 0;
        while (!done && n < 400) begin
            n++;
            @(negedge clk);
        end
        check("hold_second_done", {30'd0, done, fail}, 32'd2);

        // Mid-run reset at RUN cycle 50
        pulse_start;
        repeat (50) @(negedge clk);
        check("midrst_pre_busy", {31'd0, busy}, 32'd1);
        nreset = 1'b0;
        #1;
        check("midrst_status", {28'd0, busy, done, fail, mem_ce}, 32'd0);
        check("midrst_mem", {mem_we, mem_addr, mem_wmask, mem_din, fail_elem}, 24'd0);
        check("midrst_cw2", {30'd0, busy_b, mem_ce_b}, 32'd0);
        @(negedge clk) nreset = 1'b1;
        pulse_start;
        measure(bc, cc, pe);
        check("midrst_rerun_busy", bc, 161);
        check("midrst_rerun_seq", pe, 0);
        check("midrst_rerun_done", {30'd0, done, fail}, 32'd2);

        // All cells stuck-at-0: CW=2 counter saturates
        fault_all = 1'b1; sa0_mask = 8'hFF;
        pulse_start;
        measure(bc, cc, pe);
        check("all0_cw2_done_fail", {30'd0, done_b, fail_b}, 32'd3);
        check("all0_cw2_count", fail_count_b, 3);
        check("all0_cw2_addr", fail_addr_b, 0);
        check("all0_cw2_elem", fail_elem_b, 2);
        check("all0_cw16_count", fail_count, 32);
        check("all0_cw16_first", {fail_addr, fail_elem}, {4'd0, 3'd2});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
